conv_window_buf: RTL and testbench
==================================

Name: conv_window_buf

Overview:
Parametrised sliding-window line buffer for the CNN convolution stages. It accepts a row-major pixel stream with a valid qualifier and emits one KxK window per valid output position, with configurable kernel size and stride. Back-to-back frames and a mid-frame synchronous clear are supported. It sits between a feature-map source (input DMA or previous pool/conv stage) and the KxK MAC array.

Parameters:
WIDTH, 15, frame width in pixels (WIDTH >= K)
HEIGHT, 19, frame height in pixels (HEIGHT >= K)
DATA_BITS, 32, pixel width in bits
K, 3, kernel size (2..7)
STRIDE, 1, window stride in both directions (1 <= STRIDE <= K)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
sync_clr  in  1  synchronous frame restart: clears counters and output flags, keeps memory
valid_in  in  1  data_in is accepted on this cycle
data_in  in  DATA_BITS  pixel, row-major order
data_out  out  K*K*DATA_BITS  window; slice i = [i*DATA_BITS +: DATA_BITS], i = r*K + c, r=0 top (oldest) row, c=0 leftmost
valid_out  out  1  data_out holds a new window this cycle (1-cycle pulse per window)
frame_done  out  1  pulse coincident with the last window of a frame

Behaviour:
- Reset (rst_n=0 at a clk edge): valid_out=0, frame_done=0, data_out=0, in_col=0, in_row=0. Line memory is not reset; its contents are don't-care.
- Storage: K rows of WIDTH words, either circular or K-1 line FIFOs plus a KxK shift window. Implementation choice; output must be identical.
- Input counters: in_col 0..WIDTH-1 and in_row 0..HEIGHT-1, advanced only when valid_in=1.
  - in_col wraps at WIDTH-1 and increments in_row.
  - After pixel (HEIGHT-1, WIDTH-1), both counters return to 0. The next frame can start on the very next cycle with no gap.
- Window emission: on acceptance of pixel (r,c), where r >= K-1, c >= K-1, (r-K+1)%STRIDE==0 and (c-K+1)%STRIDE==0:
  - the next cycle asserts valid_out=1;
  - data_out = the pixels rows r-K+1..r, cols c-K+1..c.
  - Latency is exactly 1 cycle from the accepting edge.
- Window count per frame: OUT_W*OUT_H, with OUT_W = (WIDTH-K)/STRIDE+1 and OUT_H = (HEIGHT-K)/STRIDE+1 (integer division). Trailing columns and rows that do not fit a full stride step produce no window.
- frame_done=1 in the same cycle as valid_out for the window whose bottom-right pixel is the last emitting position of the frame. Otherwise frame_done=0.
- When valid_out=0, data_out holds its previous value (never X).
- Gaps in valid_in only stretch timing; window contents and order are unchanged. No backpressure: the consumer must accept every valid_out.
- Windows never contain data from the previous frame. Row gating (r >= K-1) guarantees this; a frame boundary needs no flush.
- sync_clr=1: in_col=0, in_row=0, valid_out=0, frame_done=0 on the next cycle. data_out and memory are held.
  - If valid_in=1 in the same cycle, data_in is accepted as pixel (0,0) of the new frame.
  - rst_n=0 overrides sync_clr.
- Reset or sync_clr mid-frame discards the partial frame. No window is emitted from pre-clear data.
- Index arithmetic is sized with $clog2 of WIDTH, HEIGHT and K*WIDTH. Modulo-STRIDE checks use separate phase counters, not dividers.

Test Plan:
- WIDTH=5, HEIGHT=4, K=3, STRIDE=1, pixel value = r*5+c, valid_in held 1 -> first valid_out on the cycle after pixel 12 is accepted, window {0,1,2,5,6,7,10,11,12}; 6 windows total; last window {7,8,9,12,13,14,17,18,19} with frame_done=1.
- WIDTH=7, HEIGHT=5, K=3, STRIDE=2 -> 6 windows; first {0,1,2,7,8,9,14,15,16}, second {2,3,4,9,10,11,16,17,18}; no windows ending at odd columns; frame_done on window ending at pixel 34.
- Case 1 with valid_in toggling 1,0,1,0 and random 0-3 cycle bubbles -> identical window sequence; each valid_out exactly 1 cycle after its accepting edge; data_out stable between pulses.
- Two back-to-back frames of case 1, frame 2 values +100 -> 12 windows; frame 2 first window {100,101,102,105,106,107,110,111,112}, no value below 100; two frame_done pulses.
- sync_clr asserted after 8 pixels of frame A, same cycle as valid_in with value 200, then the rest of frame B -> no window before B pixel (2,2); B output matches a clean run. Repeat using rst_n=0 in place of sync_clr: outputs return to 0 and the same clean result follows.
- K=5, WIDTH=5, HEIGHT=5, STRIDE=1 -> exactly one window = all 25 pixels in order 0..24, with valid_out=frame_done=1 on the same cycle.

Source files
------------

// File: rtl/conv_window_buf.sv
// Sliding KxK window line buffer: K-1 line memories feed a KxK shift window, and one
// registered window is emitted per accepted pixel that lands on a stride-aligned position.
module conv_window_buf #(
    parameter int unsigned WIDTH     = 15,
    parameter int unsigned HEIGHT    = 19,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned K         = 3,
    parameter int unsigned STRIDE    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sync_clr,
    input  logic                     valid_in,
    input  logic [DATA_BITS-1:0]     data_in,
    output logic [K*K*DATA_BITS-1:0] data_out,
    output logic                     valid_out,
    output logic                     frame_done
);

    localparam int unsigned CW     = $clog2(WIDTH);
    localparam int unsigned RW     = $clog2(HEIGHT);
    localparam int unsigned PW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int unsigned OUT_W  = (WIDTH - K) / STRIDE + 1;
    localparam int unsigned OUT_H  = (HEIGHT - K) / STRIDE + 1;
    localparam int unsigned LAST_C = K - 1 + (OUT_W - 1) * STRIDE;
    localparam int unsigned LAST_R = K - 1 + (OUT_H - 1) * STRIDE;

    localparam logic [CW-1:0] COL_MAX  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(LAST_C);
    localparam logic [RW-1:0] ROW_MAX  = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(LAST_R);
    localparam logic [PW-1:0] PH_MAX   = PW'(STRIDE - 1);

    logic [CW-1:0] in_col, cur_col;
    logic [RW-1:0] in_row, cur_row;
    logic [PW-1:0] col_ph, cur_col_ph;
    logic [PW-1:0] row_ph, cur_row_ph;
    logic          accept, emit, last_win;

    logic [DATA_BITS-1:0]     line_mem [K-1][WIDTH];
    logic [DATA_BITS-1:0]     win      [K][K];
    logic [DATA_BITS-1:0]     win_nxt  [K][K];
    logic [DATA_BITS-1:0]     col_vec  [K];
    logic [K*K*DATA_BITS-1:0] win_flat;

    // A clear in the same cycle as valid_in makes this pixel (0,0) of the new frame.
    always_comb begin
        cur_col    = sync_clr ? '0 : in_col;
        cur_row    = sync_clr ? '0 : in_row;
        cur_col_ph = sync_clr ? '0 : col_ph;
        cur_row_ph = sync_clr ? '0 : row_ph;
        accept     = valid_in & rst_n;
        emit       = accept && (cur_col >= COL_WIN) && (cur_row >= ROW_WIN) &&
                     (cur_col_ph == '0) && (cur_row_ph == '0);
        last_win   = emit && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    end

    always_comb begin
        for (int unsigned j = 0; j + 1 < K; j++) begin
            col_vec[j] = line_mem[j][cur_col];
        end
        col_vec[K-1] = data_in;
        win_flat = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c + 1 < K; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
            win_nxt[r][K-1] = col_vec[r];
            for (int unsigned c = 0; c < K; c++) begin
                win_flat[(r*K+c)*DATA_BITS +: DATA_BITS] = win_nxt[r][c];
            end
        end
    end

    // Line memories shift one row older per accepted pixel at the same column.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned j = 0; j + 2 < K; j++) begin
                line_mem[j][cur_col] <= line_mem[j+1][cur_col];
            end
            line_mem[K-2][cur_col] <= data_in;
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c < K; c++) begin
                    win[r][c] <= win_nxt[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_col     <= '0;
            in_row     <= '0;
            col_ph     <= '0;
            row_ph     <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
        end else begin
            valid_out  <= emit;
            frame_done <= last_win;
            if (emit) begin
                data_out <= win_flat;
            end
            if (accept) begin
                if (cur_col == COL_MAX) begin
                    in_col <= '0;
                    col_ph <= '0;
                    if (cur_row == ROW_MAX) begin
                        in_row <= '0;
                        row_ph <= '0;
                    end else begin
                        in_row <= cur_row + 1'b1;
                        if (cur_row >= ROW_WIN) begin
                            row_ph <= (cur_row_ph == PH_MAX) ? '0 : cur_row_ph + 1'b1;
                        end else begin
                            row_ph <= cur_row_ph;
                        end
                    end
                end else begin
                    in_col <= cur_col + 1'b1;
                    in_row <= cur_row;
                    row_ph <= cur_row_ph;
                    if (cur_col >= COL_WIN) begin
                        col_ph <= (cur_col_ph == PH_MAX) ? '0 : cur_col_ph + 1'b1;
                    end else begin
                        col_ph <= cur_col_ph;
                    end
                end
            end else if (sync_clr) begin
                in_col <= '0;
                in_row <= '0;
                col_ph <= '0;
                row_ph <= '0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_buf.sv
// Bench for conv_window_buf: three geometries, a pixel-level reference model feeding a
// scoreboard of expected windows, a scenario table and clear/reset corner sequences.
module tb_conv_window_buf;

    typedef struct {
        int          dut;
        logic [799:0] win;
        bit          done;
        longint      due;
    } exp_t;

    typedef struct {
        int dut;
        int frames;
        bit bub;
        int exp_wins;
        int exp_first;
        int exp_last;
        int exp_done;
    } case_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        vin [3];
    logic        clr [3];
    logic [31:0] din [3];
    logic        vo  [3];
    logic        fd  [3];
    logic [287:0] out_a, out_b;
    logic [799:0] out_c;
    logic [799:0] dout [3];
    logic [799:0] last [3];

    assign dout[0] = 800'(out_a);
    assign dout[1] = 800'(out_b);
    assign dout[2] = out_c;

    conv_window_buf #(.WIDTH(5), .HEIGHT(4), .DATA_BITS(32), .K(3), .STRIDE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .sync_clr(clr[0]), .valid_in(vin[0]), .data_in(din[0]),
        .data_out(out_a), .valid_out(vo[0]), .frame_done(fd[0]));
    conv_window_buf #(.WIDTH(7), .HEIGHT(5), .DATA_BITS(32), .K(3), .STRIDE(2)) u_b (
        .clk(clk), .rst_n(rst_n), .sync_clr(clr[1]), .valid_in(vin[1]), .data_in(din[1]),
        .data_out(out_b), .valid_out(vo[1]), .frame_done(fd[1]));
    conv_window_buf #(.WIDTH(5), .HEIGHT(5), .DATA_BITS(32), .K(5), .STRIDE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .sync_clr(clr[2]), .valid_in(vin[2]), .data_in(din[2]),
        .data_out(out_c), .valid_out(vo[2]), .frame_done(fd[2]));

    int pw [3] = '{5, 7, 5};
    int ph [3] = '{4, 5, 5};
    int pk [3] = '{3, 3, 5};
    int ps [3] = '{1, 2, 1};

    int     checks = 0;
    int     errors = 0;
    int     win_cnt, done_cnt, first_e0, last_en;
    int     img [8][8];
    int     mr = 0, mc = 0;
    exp_t   q [$];
    longint cyc = 0;
    logic   rst_q = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    always @(negedge clk) begin : mon
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (!rst_q) begin
                checks++;
                if (vo[d] !== 1'b0 || fd[d] !== 1'b0 || dout[d] !== '0) begin
                    errors++;
                    $display("FAIL reset dut%0d: got valid_out=%0b frame_done=%0b data_out_zero=%0b, exp 0 0 1",
                             d, vo[d], fd[d], dout[d] == '0);
                end
                last[d] = '0;
            end else if (vo[d]) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious dut%0d cyc %0d: got valid_out=1 e0=%0d, exp no window",
                             d, cyc, dout[d][31:0]);
                end else begin
                    e = q.pop_front();
                    if (e.dut != d || e.win !== dout[d] || e.done != fd[d] || e.due != cyc) begin
                        errors++;
                        $display("FAIL window dut%0d cyc %0d: got e0=%0d done=%0b, exp dut%0d e0=%0d done=%0b due=%0d",
                                 d, cyc, dout[d][31:0], fd[d], e.dut, e.win[31:0], e.done, e.due);
                    end
                    win_cnt++;
                    if (fd[d]) done_cnt++;
                    if (win_cnt == 1) first_e0 = int'(dout[d][31:0]);
                    last_en = int'(dout[d][(pk[d]*pk[d]-1)*32 +: 32]);
                end
                last[d] = dout[d];
            end else begin
                checks++;
                if (fd[d] !== 1'b0 || dout[d] !== last[d]) begin
                    errors++;
                    $display("FAIL hold dut%0d cyc %0d: got frame_done=%0b e0=%0d, exp 0 and e0=%0d",
                             d, cyc, fd[d], dout[d][31:0], last[d][31:0]);
                end
            end
        end
        if (rst_q && q.size() > 0 && q[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing dut%0d cyc %0d: got no valid_out, exp window e0=%0d",
                     q[0].dut, cyc, q[0].win[31:0]);
            void'(q.pop_front());
        end
    end

    task automatic model_accept(input int d, input int val);
        int k, s, w, h, lastc, lastr;
        exp_t e;
        k = pk[d]; s = ps[d]; w = pw[d]; h = ph[d];
        img[mr][mc] = val;
        if (mr >= k - 1 && mc >= k - 1 && (mr - k + 1) % s == 0 && (mc - k + 1) % s == 0) begin
            e.win = '0;
            for (int i = 0; i < k * k; i++) begin
                e.win[i*32 +: 32] = img[mr-k+1+i/k][mc-k+1+i%k];
            end
            lastc  = k - 1 + ((w - k) / s) * s;
            lastr  = k - 1 + ((h - k) / s) * s;
            e.done = (mr == lastr && mc == lastc);
            e.due  = cyc + 1;
            e.dut  = d;
            q.push_back(e);
        end
        if (mc == w - 1) begin
            mc = 0;
            mr = (mr == h - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    task automatic drive(input int d, input bit v, input int val, input bit c);
        for (int i = 0; i < 3; i++) begin
            vin[i] = 1'b0;
            clr[i] = 1'b0;
            din[i] = '0;
        end
        vin[d] = v;
        clr[d] = c;
        din[d] = val;
        if (c) begin
            mr = 0;
            mc = 0;
        end
        if (v) model_accept(d, val);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d, exp %0d", name, got, expv);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) drive(0, 1'b0, 0, 1'b0);
        rst_n = 1'b1;
        mr = 0;
        mc = 0;
    endtask

    task automatic drain();
        repeat (4) drive(0, 1'b0, 0, 1'b0);
        check("drain", q.size(), 0);
    endtask

    task automatic run_frame(input int d, input int base, input bit bub, input bit clr_first);
        int idx;
        for (int r = 0; r < ph[d]; r++) begin
            for (int c = 0; c < pw[d]; c++) begin
                idx = r * pw[d] + c;
                drive(d, 1'b1, base + idx, clr_first && idx == 0);
                if (bub) begin
                    if (idx % 2 == 0) drive(d, 1'b0, 0, 1'b0);
                    else repeat ($urandom_range(0, 3)) drive(d, 1'b0, 0, 1'b0);
                end
            end
        end
    endtask

    task automatic clear_stats();
        win_cnt  = 0;
        done_cnt = 0;
        first_e0 = -1;
        last_en  = -1;
    endtask

    initial begin
        case_t tbl [5];
        tbl[0] = '{dut: 0, frames: 1, bub: 1'b0, exp_wins: 6,  exp_first: 0, exp_last: 19,  exp_done: 1};
        tbl[1] = '{dut: 1, frames: 1, bub: 1'b0, exp_wins: 6,  exp_first: 0, exp_last: 34,  exp_done: 1};
        tbl[2] = '{dut: 0, frames: 1, bub: 1'b1, exp_wins: 6,  exp_first: 0, exp_last: 19,  exp_done: 1};
        tbl[3] = '{dut: 0, frames: 2, bub: 1'b0, exp_wins: 12, exp_first: 0, exp_last: 119, exp_done: 2};
        tbl[4] = '{dut: 2, frames: 1, bub: 1'b0, exp_wins: 1,  exp_first: 0, exp_last: 24,  exp_done: 1};

        do_reset(3);
        for (int t = 0; t < 5; t++) begin
            clear_stats();
            for (int f = 0; f < tbl[t].frames; f++) begin
                run_frame(tbl[t].dut, f * 100, tbl[t].bub, 1'b0);
            end
            drain();
            check($sformatf("case%0d windows", t), win_cnt, tbl[t].exp_wins);
            check($sformatf("case%0d first", t), first_e0, tbl[t].exp_first);
            check($sformatf("case%0d last", t), last_en, tbl[t].exp_last);
            check($sformatf("case%0d frame_done", t), done_cnt, tbl[t].exp_done);
        end

        // Mid-frame sync_clr, coincident with the first pixel of the new frame.
        clear_stats();
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 50 + i, 1'b0);
        run_frame(0, 200, 1'b0, 1'b1);
        drain();
        check("clr windows", win_cnt, 6);
        check("clr first", first_e0, 200);
        check("clr last", last_en, 219);
        check("clr frame_done", done_cnt, 1);

        // Same abandoned frame, recovered by reset instead.
        clear_stats();
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 50 + i, 1'b0);
        do_reset(2);
        run_frame(0, 200, 1'b0, 1'b0);
        drain();
        check("rst windows", win_cnt, 6);
        check("rst first", first_e0, 200);
        check("rst last", last_en, 219);
        check("rst frame_done", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
